// File: rtl/pattern_detect_pkg.sv
// pattern_detect_pkg: shared constants, types and helpers for the serial
// pattern detector.
package pattern_detect_pkg;

    // Legal bounds for the pattern length parameter.
    localparam int PAT_LEN_MIN = 2;
    localparam int PAT_LEN_MAX = 16;

    // Decode of the overlap-mode input.
    typedef enum logic {
        MODE_NONOVERLAP = 1'b0,
        MODE_OVERLAP    = 1'b1
    } detect_mode_e;

    // Width needed to hold a fill count of 0..plen inclusive.
    function automatic int fill_width(input int plen);
        return $clog2(plen + 1);
    endfunction

endpackage : pattern_detect_pkg

// File: rtl/pattern_detect_if.sv
// pattern_detect_if: control/stream/result bundle of the pattern detector.
// The clock and reset stay as plain ports on the design.
interface pattern_detect_if #(
    parameter int PAT_LEN = 4,
    parameter int CNT_W   = 8
) ();

    logic               i_clear;
    logic [PAT_LEN-1:0] i_pattern;
    logic               i_overlap;
    logic               i_valid;
    logic               i_data;
    logic               o_detect;
    logic [CNT_W-1:0]   o_count;

    // Stimulus side (drives the stream and control).
    modport master (
        output i_clear,
        output i_pattern,
        output i_overlap,
        output i_valid,
        output i_data,
        input  o_detect,
        input  o_count
    );

    // Detector side.
    modport slave (
        input  i_clear,
        input  i_pattern,
        input  i_overlap,
        input  i_valid,
        input  i_data,
        output o_detect,
        output o_count
    );

endinterface : pattern_detect_if

// File: rtl/pattern_detect_sat_counter.sv
// sat_counter: generic saturating up-counter with synchronous active-low
// reset, synchronous clear and an increment enable. Holds at all-ones.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear beats increment, increment stops at the maximum.
    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = {CNT_W{1'b0}};
        end else if (i_inc && (count_q != CNT_MAX)) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;

endmodule : sat_counter

// File: rtl/pattern_detect.sv
// pattern_detect: programmable serial pattern detector with overlapping or
// non-overlapping matching, input qualifier and a registered match pulse.
// Build option: define PATTERN_DETECT_COUNT_EN to build the saturating
// match counter; without it o_count is tied to zero.
module pattern_detect
    import pattern_detect_pkg::*;
#(
    parameter int PAT_LEN = 4,
    parameter int CNT_W   = 8
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    pattern_detect_if.slave    bus
);

    localparam int                FILL_W    = fill_width(PAT_LEN);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
    localparam logic [FILL_W-1:0] FILL_ARM  = FILL_W'(PAT_LEN - 1);
    localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);

    // Reject out-of-range pattern lengths at elaboration.
    if ((PAT_LEN < PAT_LEN_MIN) || (PAT_LEN > PAT_LEN_MAX)) begin : g_pat_len_bad
        $error("pattern_detect: PAT_LEN outside legal range");
    end

    logic [PAT_LEN-1:0] pat_q;
    logic [PAT_LEN-1:0] pat_d;
    logic [PAT_LEN-1:0] hist_q;
    logic [PAT_LEN-1:0] hist_d;
    logic [FILL_W-1:0]  fill_q;
    logic [FILL_W-1:0]  fill_d;
    logic               detect_q;
    logic               detect_d;
    logic [PAT_LEN-1:0] shifted_s;
    logic               match_s;
    detect_mode_e       mode_s;

    // Candidate history after accepting the current bit (newest at LSB).
    always_comb begin
        shifted_s = {hist_q[PAT_LEN-2:0], bus.i_data};
        mode_s    = detect_mode_e'(bus.i_overlap);
    end

    // Fill-state machine and match evaluation. The fill count is the state:
    // below PAT_LEN-1 no match is possible; at PAT_LEN-1 or PAT_LEN the bit
    // being accepted can complete one. Clear discards the current bit.
    always_comb begin
        pat_d    = pat_q;
        hist_d   = hist_q;
        fill_d   = fill_q;
        detect_d = 1'b0;
        match_s  = 1'b0;
        if (bus.i_clear) begin
            pat_d  = bus.i_pattern;
            hist_d = {PAT_LEN{1'b0}};
            fill_d = {FILL_W{1'b0}};
        end else if (bus.i_valid) begin
            hist_d  = shifted_s;
            match_s = (fill_q >= FILL_ARM) && (shifted_s == pat_q);
            if (match_s) begin
                case (mode_s)
                    MODE_OVERLAP:    fill_d = FILL_FULL;
                    MODE_NONOVERLAP: fill_d = {FILL_W{1'b0}};
                    default:         fill_d = {FILL_W{1'b0}};
                endcase
            end else if (fill_q != FILL_FULL) begin
                fill_d = fill_q + FILL_ONE;
            end else begin
                fill_d = fill_q;
            end
            detect_d = match_s;
        end else begin
            detect_d = 1'b0;
        end
    end

    // State registers; reset reloads the pattern and empties the history.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            pat_q    <= bus.i_pattern;
            hist_q   <= {PAT_LEN{1'b0}};
            fill_q   <= {FILL_W{1'b0}};
            detect_q <= 1'b0;
        end else begin
            pat_q    <= pat_d;
            hist_q   <= hist_d;
            fill_q   <= fill_d;
            detect_q <= detect_d;
        end
    end

    assign bus.o_detect = detect_q;

`ifdef PATTERN_DETECT_COUNT_EN
    logic [CNT_W-1:0] count_s;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_sat_counter (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_clear (bus.i_clear),
        .i_inc   (match_s),
        .o_count (count_s)
    );

    assign bus.o_count = count_s;
`else
    assign bus.o_count = {CNT_W{1'b0}};
`endif

endmodule : pattern_detect

// File: tb/tb_pattern_detect.sv
// tb_pattern_detect: scoreboard bench for pattern_detect. Two instances:
// A (PAT_LEN=4, CNT_W=8) and B (PAT_LEN=2, CNT_W=2, for saturation).
module tb_pattern_detect;

    logic clk = 1'b0;
    logic rstn_a = 1'b0;
    logic rstn_b = 1'b0;

    always #5 clk = ~clk;

    pattern_detect_if #(.PAT_LEN(4), .CNT_W(8)) if_a ();
    pattern_detect_if #(.PAT_LEN(2), .CNT_W(2)) if_b ();

    pattern_detect #(.PAT_LEN(4), .CNT_W(8)) u_dut_a (
        .i_clk  (clk),
        .i_rstn (rstn_a),
        .bus    (if_a.slave)
    );

    pattern_detect #(.PAT_LEN(2), .CNT_W(2)) u_dut_b (
        .i_clk  (clk),
        .i_rstn (rstn_b),
        .bus    (if_b.slave)
    );

    int          checks = 0;
    int          errors = 0;
    int          sel    = 0;
    int          plen   = 4;
    int          cmax   = 255;
    int          m_cnt  = 0;
    int          pulses = 0;
    logic [15:0] m_pat  = 16'd0;
    bit          fresh[$];
    logic [31:0] sb_det[$];
    logic [31:0] sb_cnt[$];

    initial begin
        if_a.i_clear = 1'b0; if_a.i_pattern = 4'd0; if_a.i_overlap = 1'b0;
        if_a.i_valid = 1'b0; if_a.i_data = 1'b0;
        if_b.i_clear = 1'b0; if_b.i_pattern = 2'd0; if_b.i_overlap = 1'b0;
        if_b.i_valid = 1'b0; if_b.i_data = 1'b0;
    end

    // One cycle: drive the selected DUT, update the reference model, push the
    // expectation, then pop and compare against the registered outputs.
    task automatic step(input logic rstn, input logic clr, input logic valid,
                        input logic data, input logic ovl, input logic [15:0] pat);
        logic [15:0] w;
        logic [15:0] mask;
        logic [31:0] e_det, e_cnt, o_det, o_cnt;
        int          exp_det;
        @(negedge clk);
        if (sel == 0) begin
            rstn_a = rstn; if_a.i_clear = clr; if_a.i_valid = valid;
            if_a.i_data = data; if_a.i_overlap = ovl; if_a.i_pattern = pat[3:0];
            rstn_b = 1'b1; if_b.i_clear = 1'b0; if_b.i_valid = 1'b0;
        end else begin
            rstn_b = rstn; if_b.i_clear = clr; if_b.i_valid = valid;
            if_b.i_data = data; if_b.i_overlap = ovl; if_b.i_pattern = pat[1:0];
            rstn_a = 1'b1; if_a.i_clear = 1'b0; if_a.i_valid = 1'b0;
        end
        exp_det = 0;
        mask = 16'((32'd1 << plen) - 32'd1);
        if (!rstn || clr) begin
            m_pat = pat & mask;
            fresh.delete();
            m_cnt = 0;
        end else if (valid) begin
            fresh.push_back(data);
            if (fresh.size() > plen) void'(fresh.pop_front());
            if (fresh.size() == plen) begin
                w = 16'd0;
                foreach (fresh[i]) w = {w[14:0], fresh[i]};
                if (w == m_pat) begin
                    exp_det = 1;
                    if (m_cnt < cmax) m_cnt++;
                    if (!ovl) fresh.delete();
                end
            end
        end
        sb_det.push_back(32'(exp_det));
`ifdef PATTERN_DETECT_COUNT_EN
        sb_cnt.push_back(32'(m_cnt));
`else
        sb_cnt.push_back(32'd0);
`endif
        @(posedge clk);
        #1;
        e_det = sb_det.pop_front();
        e_cnt = sb_cnt.pop_front();
        if (sel == 0) begin
            o_det = {31'd0, if_a.o_detect};
            o_cnt = 32'(if_a.o_count);
        end else begin
            o_det = {31'd0, if_b.o_detect};
            o_cnt = 32'(if_b.o_count);
        end
        checks++;
        if (o_det !== e_det) begin
            errors++;
            $display("FAIL detect dut=%0d t=%0t got %0d want %0d", sel, $time, o_det, e_det);
        end
        checks++;
        if (o_cnt !== e_cnt) begin
            errors++;
            $display("FAIL count dut=%0d t=%0t got %0d want %0d", sel, $time, o_cnt, e_cnt);
        end
        if (o_det === 32'd1) pulses++;
    endtask

    task automatic select_a();
        sel = 0; plen = 4; cmax = 255;
    endtask

    task automatic test_reset();
        sel = 1; plen = 2; cmax = 3;
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0003);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0003);
        select_a();
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h000F);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h000F);
    endtask

    task automatic test_legacy_1111();
        select_a();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h000F);
        pulses = 0;
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000);
        checks++;
        if (pulses != 3) begin
            errors++;
            $display("FAIL legacy_pulses got %0d want 3", pulses);
        end
    endtask

    task automatic test_nonoverlap();
        select_a();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h000F);
        pulses = 0;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0005);
        checks++;
        if (pulses != 2) begin
            errors++;
            $display("FAIL nonoverlap_pulses got %0d want 2", pulses);
        end
    endtask

    task automatic test_gaps();
        logic [6:0] bits;
        bits = 7'b1011011;
        select_a();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h000B);
        pulses = 0;
        for (int i = 6; i >= 0; i--) begin
            if (i == 3) begin
                step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
                step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h000F);
            end
            step(1'b1, 1'b0, 1'b1, bits[i], 1'b1, 16'h0000);
        end
        checks++;
        if (pulses != 2) begin
            errors++;
            $display("FAIL gaps_pulses got %0d want 2", pulses);
        end
    endtask

    task automatic test_clear_reset();
        select_a();
        for (int mode = 0; mode < 2; mode++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h000F);
            pulses = 0;
            for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h000F);
            if (mode == 0) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h000F);
            else           step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h000F);
            for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h000F);
            checks++;
            if (pulses != 0) begin
                errors++;
                $display("FAIL early_detect mode=%0d got %0d want 0", mode, pulses);
            end
            step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h000F);
            checks++;
            if (pulses != 1) begin
                errors++;
                $display("FAIL late_detect mode=%0d got %0d want 1", mode, pulses);
            end
        end
    endtask

    task automatic test_saturation();
        logic [31:0] want;
        sel = 1; plen = 2; cmax = 3;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0003);
        pulses = 0;
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000);
`ifdef PATTERN_DETECT_COUNT_EN
        want = 32'd3;
`else
        want = 32'd0;
`endif
        checks++;
        if (32'(if_b.o_count) !== want) begin
            errors++;
            $display("FAIL sat_count got %0d want %0d", if_b.o_count, want);
        end
        checks++;
        if (pulses != 9) begin
            errors++;
            $display("FAIL sat_pulses got %0d want 9", pulses);
        end
    endtask

    task automatic test_back_to_back();
        logic clr;
        logic [15:0] pat;
        select_a();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0006);
        for (int i = 0; i < 400; i++) begin
            clr = ($urandom_range(0, 29) == 0);
            pat = 16'($urandom_range(0, 15));
            step(1'b1, clr, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), pat);
        end
    endtask

    initial begin
        test_reset();
        test_legacy_1111();
        test_nonoverlap();
        test_gaps();
        test_clear_reset();
        test_saturation();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pattern_detect

// File: doc/pattern_detect.md
# pattern_detect

Parametrised serial pattern detector: programmable pattern of `PAT_LEN` bits, overlapping or non-overlapping match mode, input qualifier and a saturating match counter. It is the generalised successor to the fixed "1111" detector. It sits on a single-bit serial stream inside the sequential-blocks area and flags each completed match with a one-cycle pulse.

## Interface
- `PAT_LEN`, default 4: pattern length in bits. Legal range is 2..16.
- `CNT_W`, default 8: width of the match counter.
- `i_clk` input, 1 bit: sole clock; all logic on the rising edge.
- `i_rstn` input, 1 bit: reset, synchronous, active-low.
- `i_clear` input, 1 bit: synchronous soft clear; also reloads the pattern.
- `i_pattern` input, `PAT_LEN` bits: target pattern. Bit `[PAT_LEN-1]` is matched against the oldest bit.
- `i_overlap` input, 1 bit: 1 = overlapping matches, 0 = non-overlapping.
- `i_valid` input, 1 bit: qualifies `i_data`; bits with `i_valid`=0 are ignored.
- `i_data` input, 1 bit: serial data bit.
- `o_detect` output, 1 bit: registered one-cycle match pulse.
- `o_count` output, `CNT_W` bits: saturating count of matches.

## Operation
- **Pattern register `pat_q`:** loaded from `i_pattern` on any cycle where `i_rstn`=0 or `i_clear`=1. It holds its value otherwise, so mid-stream changes on `i_pattern` are ignored.
- **History register `hist_q`** (`PAT_LEN` bits):
  - On each accepted bit (`i_valid`=1), `hist_q <= {hist_q[PAT_LEN-2:0], i_data}`.
  - The newest bit sits at the LSB.
- **Fill counter `fill_q`** (0..`PAT_LEN`) acts as the FSM state, with states FILL_0 .. FILL_N:
  - Each accepted bit increments `fill_q`, saturating at `PAT_LEN` (state ARMED).
- **Match condition:** `i_valid`=1, the post-shift fill is at least `PAT_LEN`, and `{hist_q[PAT_LEN-2:0], i_data} == pat_q`.
- **On a match:**
  - `o_detect` is 1 on the next cycle.
  - The counter increments.
  - If `i_overlap`=1, `fill_q` stays at `PAT_LEN`, so the next bit can complete another match.
  - If `i_overlap`=0, `fill_q` goes to 0 and `hist_q` is kept but ignored, so the next match needs `PAT_LEN` fresh bits.
- **Non-match accepted bit:** `o_detect` is 0 on the next cycle.
- **Cycle with `i_valid`=0:** no shift and no fill change; `o_detect` is 0 on the next cycle.
- **Counter:** increments by 1 per match and holds at `2^CNT_W-1` (no wrap).
- **Clear and reset:**
  - `i_clear`=1 takes priority over `i_valid`; the bit in that cycle is discarded.
  - `i_clear` sets `hist_q`=0, `fill_q`=0, `o_detect`=0 and `o_count`=0.
  - Reset has the same effect as `i_clear` and wins over everything. A reset mid-pattern discards any partial match.
- `i_overlap` is sampled on the matching cycle only.

## Timing
- **Reset values:** `o_detect`=0, `o_count`=0, `hist_q`=0, `fill_q`=0; `pat_q` is loaded from `i_pattern`.
- **Latency:** 1 cycle from the accepted bit that completes the pattern to `o_detect`=1. `o_count` updates in the same cycle as `o_detect`.
- **Earliest match:** after reset or clear, the first possible `o_detect` follows the `PAT_LEN`-th accepted bit.
- **Maximum rate:** back-to-back `o_detect` pulses, one per accepted bit, are possible only with `i_overlap`=1.
- No combinational path from inputs to outputs.

## Configuration
- **`PATTERN_DETECT_COUNT_EN` defined:** the match counter is built as described.
- **Not defined:** no counter flops are built and `o_count` is tied to 0. Detection behaviour is unchanged.

## Structure
- **Package `pattern_detect_pkg`:**
  - Constants `PAT_LEN_MIN`=2 and `PAT_LEN_MAX`=16.
  - Typedef `detect_mode_e` with values `MODE_NONOVERLAP`=0 and `MODE_OVERLAP`=1, used for `i_overlap` decode.
- **Parameter check:** elaboration-time check that `PAT_LEN` lies within the package bounds.
- **Sub-module `sat_counter`:** generic `CNT_W` saturating counter with synchronous active-low reset, clear and increment enable. It is instantiated only under `PATTERN_DETECT_COUNT_EN`.

## Test plan
1. **Legacy 1111 case:**
   - Setup: `PAT_LEN`=4, pattern 4'b1111, overlap=1.
   - Stimulus: six 1s with `i_valid`=1.
   - Response: `o_detect` high on the 3 cycles following bits 4, 5 and 6; `o_count`=3.
2. **Non-overlap:**
   - Setup: pattern 4'b1111, overlap=0.
   - Stimulus: eight 1s.
   - Response: `o_detect` pulses only after bits 4 and 8; `o_count`=2.
3. **Programmable pattern with gaps:**
   - Setup: pattern 4'b1011.
   - Stimulus: stream 1,0,1,1,0,1,1 with `i_valid` dropped for 2 cycles mid-stream.
   - Response: pulses after the 4th and 7th accepted bits; gap cycles are ignored.
4. **Clear and reset mid-pattern:**
   - Stimulus: 1,1,1, then `i_clear` together with a valid 1, then 1,1,1.
   - Response: no detect until the 3rd bit after clear plus one more 1. Repeating the sequence with `i_rstn`=0 instead of `i_clear` gives the same result.
5. **Saturation** (`CNT_W`=2, overlap=1, pattern 2'b11): ten 1s -> `o_count` holds at 3 after the 4th match.
6. **Macro off:** same stimulus as test 1 without `PATTERN_DETECT_COUNT_EN` -> identical `o_detect` pulses; `o_count` stays 0.
